// File: rtl/sync_bus_rx_ctrl.sv
// sync_bus_rx_ctrl: toggle-handshake receiver that synchronizes a foreign request,
// waits SETTLE enabled cycles, captures the bus, and acknowledges on consumer accept.
module sync_bus_rx_ctrl #(
   parameter int WIDTH  = 32,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk__enable,
   input  logic             req_toggle,
   input  logic [WIDTH-1:0] data_in,
   output logic             ack_toggle,
   output logic [WIDTH-1:0] data_out,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic             overrun
);
   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_VALID} state_t;
   localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
   (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic r_sync1;
   (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *) logic r_req_s;
   logic             r_req_s_d;
   logic             r_req_seen;
   logic [3:0]       r_cnt;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_ack;
   logic             r_overrun;
   state_t           r_state;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1    <= 1'b0;
         r_req_s    <= 1'b0;
         r_req_s_d  <= 1'b0;
         r_req_seen <= 1'b0;
         r_cnt      <= 4'd0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_ack      <= 1'b0;
         r_overrun  <= 1'b0;
         r_state    <= S_IDLE;
      end else if (clk__enable) begin
         r_sync1   <= req_toggle;
         r_req_s   <= r_sync1;
         r_req_s_d <= r_req_s;
         // a sender that toggles again before our ack is flagged but otherwise ignored
         if (r_state != S_IDLE && r_req_s != r_req_s_d)
            r_overrun <= 1'b1;
         case (r_state)
            S_IDLE:
               if (r_req_s != r_req_seen) begin
                  r_state <= S_SETTLE;
                  r_cnt   <= CNT_INIT;
               end
            S_SETTLE:
               if (r_cnt != 4'd0)
                  r_cnt <= r_cnt - 4'd1;
               else begin
                  r_data     <= data_in;
                  r_valid    <= 1'b1;
                  r_req_seen <= r_req_s;
                  r_state    <= S_VALID;
               end
            S_VALID:
               if (data_ready) begin
                  r_valid <= 1'b0;
                  r_ack   <= ~r_ack;
                  r_state <= S_IDLE;
               end
            default: r_state <= S_IDLE;
         endcase
      end
   end
   assign ack_toggle = r_ack;
   assign data_out   = r_data;
   assign data_valid = r_valid;
   assign overrun    = r_overrun;
   assign busy       = r_state != S_IDLE;
endmodule

// File: tb/tb_sync_bus_rx_ctrl.sv
// tb_sync_bus_rx_ctrl: three receivers (SETTLE 1, 2, 4) on shared stimulus, checked
// every cycle against a countdown model plus directed literal expectations.
module tb_sync_bus_rx_ctrl;
   logic        clk = 0, reset = 0, clk__enable = 1, req_toggle = 0, data_ready = 0;
   logic [31:0] data_in = '0;
   logic [2:0]  ack, valid, busy, ovr;
   logic [31:0] dout [3];
   int          n_chk = 0, n_fail = 0;
   logic        run_cmp = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      sync_bus_rx_ctrl #(.WIDTH(32), .SETTLE(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
         .clk(clk), .reset(reset), .clk__enable(clk__enable), .req_toggle(req_toggle),
         .data_in(data_in), .ack_toggle(ack[g]), .data_out(dout[g]), .data_valid(valid[g]),
         .data_ready(data_ready), .busy(busy[g]), .overrun(ovr[g]));
   end
   function automatic int settle_of(input int i);
      return i == 0 ? 1 : (i == 1 ? 2 : 4);
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset(input logic r);
      req_toggle = r;
      #2 reset = 1;
      tick();
      tick();
      reset = 0;
   endtask
   // model: request level seen two enabled edges late; m_wait counts edges to capture
   logic [1:0]  m_hist [3];
   logic        m_prev [3], m_seen [3], m_valid [3], m_ack [3], m_ovr [3];
   int          m_wait [3];
   logic [31:0] m_dout [3];
   initial forever begin
      @(posedge clk or posedge reset);
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            m_hist[i] = 2'b00; m_prev[i] = 0; m_seen[i] = 0; m_valid[i] = 0;
            m_ack[i] = 0; m_ovr[i] = 0; m_wait[i] = 0; m_dout[i] = '0;
         end else if (clk__enable) begin
            logic synced;
            synced = m_hist[i][1];
            if ((m_wait[i] > 0 || m_valid[i]) && synced != m_prev[i]) m_ovr[i] = 1;
            if (m_valid[i]) begin
               if (data_ready) begin
                  m_valid[i] = 0;
                  m_ack[i] = ~m_ack[i];
               end
            end else if (m_wait[i] > 0) begin
               m_wait[i]--;
               if (m_wait[i] == 0) begin
                  m_dout[i] = data_in;
                  m_valid[i] = 1;
                  m_seen[i] = synced;
               end
            end else if (synced != m_seen[i])
               m_wait[i] = settle_of(i);
            m_prev[i] = synced;
            m_hist[i] = {m_hist[i][0], req_toggle};
         end
      end
   end
   initial forever begin
      @(negedge clk);
      if (run_cmp)
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d_ctl{valid,ack,busy,ovr}", i), {valid[i], ack[i], busy[i], ovr[i]},
                {m_valid[i], m_ack[i], m_wait[i] > 0 || m_valid[i], m_ovr[i]});
            chk($sformatf("u%0d_data_out", i), dout[i], m_dout[i]);
         end
   end
   initial begin
      do_reset(0);
      run_cmp = 1;
      // basic transfer
      data_ready = 1; data_in = 32'hA5A5_0001; req_toggle = 1;
      repeat (4) tick();
      chk("basic_not_early", valid[1], 0);
      tick();
      chk("basic_valid", valid[1], 1);
      chk("basic_data", dout[1], 32'hA5A5_0001);
      tick();
      chk("basic_done", {valid[1], ack[1], busy[1]}, 3'b010);
      repeat (6) tick();
      // consumer stall
      data_ready = 0; data_in = 32'h1234_5678; req_toggle = 0;
      repeat (5) tick();
      chk("stall_valid", {valid[1], dout[1]}, {1'b1, 32'h1234_5678});
      repeat (10) tick();
      chk("stall_hold", {valid[1], ack[1], dout[1]}, {1'b1, 1'b1, 32'h1234_5678});
      data_ready = 1;
      tick();
      chk("stall_ack", {valid[1], ack[1]}, 2'b00);
      repeat (6) tick();
      // enable gating
      do_reset(0);
      data_ready = 0; data_in = 32'hC0DE_0025; req_toggle = 1;
      for (int k = 1; k <= 7; k++) begin
         clk__enable = k[0];
         tick();
         if (k == 6) chk("gate_not_early", valid[0], 0);
         if (k == 7) chk("gate_valid", {valid[0], dout[0]}, {1'b1, 32'hC0DE_0025});
      end
      clk__enable = 1; data_ready = 1;
      repeat (8) tick();
      // overrun
      do_reset(0);
      data_in = 32'h0BAD_0026; req_toggle = 1;
      repeat (3) tick();
      req_toggle = 0;
      tick();
      req_toggle = 1;
      repeat (12) tick();
      chk("ovr_flag", ovr[2], 1);
      chk("ovr_once", {valid[2], ack[2], dout[2]}, {1'b0, 1'b1, 32'h0BAD_0026});
      data_in = 32'hFFFF_FFFF;
      repeat (10) tick();
      chk("ovr_no_more", {busy[2], ack[2], ovr[2], dout[2]}, {1'b0, 1'b1, 1'b1, 32'h0BAD_0026});
      // reset mid-settle
      do_reset(0);
      data_in = 32'h5EED_0027; req_toggle = 1;
      repeat (3) tick();
      chk("rst_pre_busy", busy[1], 1);
      #2 reset = 1;
      #1 chk("rst_async", {valid[1], ack[1], busy[1], ovr[1], dout[1]}, 0);
      tick();
      chk("rst_held", {valid, ack, busy, ovr}, 0);
      reset = 0;
      repeat (10) tick();
      chk("rst_retry", {valid[1], ack[1], dout[1]}, {1'b0, 1'b1, 32'h5EED_0027});
      // back-to-back
      do_reset(0);
      for (int k = 0; k < 10; k++) begin
         int n;
         data_in = 32'h1000_0000 + 32'(k);
         req_toggle = ~req_toggle;
         n = 0;
         while (ack != {3{req_toggle}} && n < 40) begin
            tick();
            n++;
         end
         chk($sformatf("b2b_ack%0d", k), ack, {3{req_toggle}});
         for (int i = 0; i < 3; i++)
            chk($sformatf("b2b_u%0d_data%0d", i, k), dout[i], 32'h1000_0000 + 32'(k));
      end
      tick();
      chk("b2b_no_ovr", ovr, 3'b000);
      chk("b2b_ack_end", {ack, req_toggle}, {3'b000, 1'b0});
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
